// File: rtl/rx_pkg.sv
// Shared defaults, the default comma pattern and a constant clog2 for the RX word assembler.
package rx_pkg;

  localparam int MAX_IN_DEF = 2;
  localparam int WORD_W_DEF = 10;
  localparam int DEPTH_DEF  = 4;

  // LSB is the first bit on the wire.
  localparam logic [9:0] COMMA_DEF = 10'b0101111100;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rx_word_fifo.sv
// Word FIFO with free-running wrap-bit pointers; a write on a full FIFO lands when a pop happens in the same cycle.
module rx_word_fifo
  import rx_pkg::*;
#(
  parameter int WIDTH = WORD_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  assign wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;

  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: storage has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/rx_word_assembler.sv
// Packs 0..MAX_IN recovered bits per cycle into WORD_W-bit words and buffers them in a small FIFO.
// Define RX_WORD_ASSEMBLER_ALIGN_EN to enable comma search and alignment lock.
module rx_word_assembler
  import rx_pkg::*;
#(
  parameter int                MAX_IN = MAX_IN_DEF,
  parameter int                WORD_W = WORD_W_DEF,
  parameter int                DEPTH  = DEPTH_DEF,
  parameter logic [WORD_W-1:0] COMMA  = WORD_W'(COMMA_DEF),
  localparam int               CNT_W  = clog2(MAX_IN + 1)
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic [MAX_IN-1:0] in_bits,
  input  logic [CNT_W-1:0]  in_cnt,
  input  logic              realign,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              align_locked,
  output logic              overflow
);

  localparam int FILL_W = clog2(WORD_W + 1);

  logic [FILL_W-1:0] fill_q, fill_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic              ovf_q;
  logic [CNT_W-1:0]  cnt_eff;
  logic              wr_en;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] rd_data;
  logic              fifo_full, fifo_empty;
  logic              pop;

`ifdef RX_WORD_ASSEMBLER_ALIGN_EN
  logic [WORD_W-1:0] hist_q, hist_d;
  logic [FILL_W-1:0] hcnt_q, hcnt_d;
  logic              lock_q, lock_d;
`endif

  // NOTE: blocking assignments are deliberate: each bit slot builds on the
  // fill/history left by the previous slot, and the defaults up front keep
  // every variable fully assigned so no latch is inferred.
  always_comb begin
    fill_d  = fill_q;
    asm_d   = asm_q;
    wr_en   = 1'b0;
    wr_word = '0;
`ifdef RX_WORD_ASSEMBLER_ALIGN_EN
    hist_d  = hist_q;
    hcnt_d  = hcnt_q;
    lock_d  = lock_q;
`endif
    cnt_eff = (in_cnt > CNT_W'(MAX_IN)) ? '0 : in_cnt;

    for (int i = 0; i < MAX_IN; i++) begin
      if (CNT_W'(i) < cnt_eff) begin
        asm_d[fill_d] = in_bits[i];
`ifdef RX_WORD_ASSEMBLER_ALIGN_EN
        // History holds the last WORD_W bits with the oldest in bit 0, matching COMMA's order.
        hist_d = {in_bits[i], hist_d[WORD_W-1:1]};
        if (hcnt_d != FILL_W'(WORD_W)) begin
          hcnt_d = hcnt_d + 1'b1;
        end
        if (!lock_d && (hcnt_d == FILL_W'(WORD_W)) && (hist_d == COMMA)) begin
          wr_en   = 1'b1;
          wr_word = hist_d;
          fill_d  = '0;
          lock_d  = 1'b1;
        end else
`endif
        if (fill_d == FILL_W'(WORD_W - 1)) begin
          fill_d = '0;
`ifdef RX_WORD_ASSEMBLER_ALIGN_EN
          if (lock_d) begin
            wr_en   = 1'b1;
            wr_word = asm_d;
          end
`else
          wr_en   = 1'b1;
          wr_word = asm_d;
`endif
        end else begin
          fill_d = fill_d + 1'b1;
        end
      end
    end

`ifdef RX_WORD_ASSEMBLER_ALIGN_EN
    if (realign) begin
      lock_d = 1'b0;
    end
`endif
  end

  assign pop = word_valid && word_ready;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      fill_q <= '0;
      asm_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      fill_q <= fill_d;
      asm_q  <= asm_d;
      if (wr_en && fifo_full && !pop) begin
        ovf_q <= 1'b1;
      end
    end
  end

`ifdef RX_WORD_ASSEMBLER_ALIGN_EN
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      hist_q <= '0;
      hcnt_q <= '0;
      lock_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      hcnt_q <= hcnt_d;
      lock_q <= lock_d;
    end
  end

  assign align_locked = lock_q;
`else
  // Boundary is fixed from reset, so realign has no effect.
  logic unused_realign;
  assign unused_realign = realign;
  assign align_locked   = 1'b1;
`endif

  rx_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .aresetn (aresetn),
    .wr_en   (wr_en),
    .wr_data (wr_word),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign word_valid = !fifo_empty;
  assign word_out   = fifo_empty ? '0 : rd_data;
  assign overflow   = ovf_q;

endmodule

// File: doc/rx_word_assembler.md
RX_WORD_ASSEMBLER -- requirements
Module: rx_word_assembler

Interface
REQ-001 SHALL have parameter MAX_IN, default 2: maximum recovered bits delivered per cycle (the data recovery unit's out/E pair).
REQ-002 SHALL have parameter WORD_W, default 10: output word width; legal only if WORD_W >= MAX_IN.
REQ-003 SHALL have parameter DEPTH, default 4: output FIFO depth in words; legal only for a power of two >= 2.
REQ-004 SHALL have parameter COMMA, default 10'b0101111100: alignment pattern, WORD_W bits, LSB = first received bit.
REQ-005 SHALL have port clk, input, 1: the single clock (100 MHz recovery domain).
REQ-006 SHALL have port aresetn, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port in_bits, input, MAX_IN: recovered bits; in_bits[0] is the oldest bit.
REQ-008 SHALL have port in_cnt, input, clog2(MAX_IN+1): number of valid bits in in_bits, 0..MAX_IN; only in_bits[in_cnt-1:0] are used.
REQ-009 SHALL have port realign, input, 1: single-cycle pulse that clears alignment lock.
REQ-010 SHALL have port word_out, output, WORD_W: FIFO head word; bit 0 = first received bit.
REQ-011 SHALL have port word_valid, output, 1: word_out is valid.
REQ-012 SHALL have port word_ready, input, 1: consumer accepts word_out.
REQ-013 SHALL have port align_locked, output, 1: word boundary locked.
REQ-014 SHALL have port overflow, output, 1: sticky flag; a completed word was dropped.

Function
REQ-015 SHALL append the in_cnt valid bits, oldest first, to an assembly register, tracking the fill count 0..WORD_W-1.
REQ-016 SHALL complete a word when the fill count reaches WORD_W; any remaining bits of that cycle SHALL start the next word in the same cycle; at most one word completes per cycle.
REQ-017 SHALL write a completed word into the FIFO at the clock edge ending the cycle in which its last bit arrives; word_valid SHALL rise on the next cycle (latency 1 cycle, last bit to word_valid).
REQ-018 SHALL pop the head word on a cycle where word_valid and word_ready are both 1; word_out SHALL be stable while word_valid=1 and word_ready=0.
REQ-019 SHALL accept a write on a full FIFO when a pop occurs in the same cycle; no overflow in that case.
REQ-020 SHALL drop a completed word on a full FIFO with no pop and set overflow=1 until reset; assembly SHALL continue uninterrupted.
REQ-021 SHALL treat in_cnt > MAX_IN as 0 (no bits consumed).
REQ-022 SHALL use free-running FIFO pointers with one extra wrap bit; full/empty SHALL be derived from the pointers, with wrap-around at DEPTH.

Reset
REQ-023 SHALL, while aresetn=0, clear fill count, assembly register, FIFO pointers, overflow and align_locked; word_valid=0 and word_out=0.
REQ-024 SHALL discard a partially assembled word and all buffered words on reset mid-operation; the first word after reset SHALL start with the first bit presented after reset release.

Configuration
REQ-025 SHALL, with macro RX_WORD_ASSEMBLER_ALIGN_EN defined, compare the last WORD_W received bits against COMMA after each individual bit insertion (MAX_IN comparisons per cycle) while align_locked=0.
REQ-026 SHALL, on a match, emit the matched WORD_W bits as one word, set the fill count to 0 after the matching bit, set align_locked=1 and place later bits of the same cycle in the next word; a partial word in progress SHALL be discarded.
REQ-027 SHALL, with the macro defined, make a realign pulse clear align_locked on the next edge; the partial word SHALL be kept until a new match occurs.
REQ-028 SHALL, without the macro, omit comparison logic, tie align_locked=1 and ignore realign; the boundary is fixed from reset.

Structure
REQ-029 SHALL take parameter defaults, the COMMA constant and a clog2 function from shared package rx_pkg.
REQ-030 SHALL implement the FIFO as sub-module rx_word_fifo (clk, aresetn, wr_en, wr_data, rd_en, rd_data, full, empty).

Verification
REQ-031 SHALL test: in_cnt=2 every cycle with 20 alternating bits 0,1,… -> two words 10'b1010101010, the first word_valid 1 cycle after the 10th bit.
REQ-032 SHALL test: in_cnt pattern 1,2,0,2,2,1,2 (10 bits) -> exactly one word, with bit order preserved across the 0-count cycle.
REQ-033 SHALL test: word_ready=0, 5 words at DEPTH=4 -> 4 words held, overflow=1; then word_ready=1 -> the 4 original words pop in order.
REQ-034 SHALL test: FIFO full and a 5th word completing on the same cycle as a pop -> no overflow, 5 words delivered.
REQ-035 SHALL test (ALIGN_EN): 3 junk bits then COMMA then 10'h155 -> first word equals COMMA, second equals 10'h155, align_locked=1; realign then COMMA offset by 1 bit -> relocks on the new boundary.
REQ-036 SHALL test: aresetn asserted with 7 bits assembled and 2 words buffered -> word_valid=0 immediately; the first word after release is built from post-reset bits only.
